// File: rtl/gpio_box_tx.sv
// gpio_box_tx: transmit side of the 3-bit GPIO box link.
// Sends (box_addr - 1) mod 8 to the external sensor/mole controller with a
// 4-phase strobe/ack handshake. The last sent code is mirrored on LEDR and
// on an active-low 7-segment digit.
module gpio_box_tx #(
    parameter int SETUP_CYCLES = 4,       // cycles gpio_data is stable before strobe rises (>=1)
    parameter int ACK_TIMEOUT  = 500000   // max cycles waited in any ack-wait state (>=2)
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       send,
    input  logic [2:0] box_addr,
    output logic       ready,
    output logic       done,
    output logic       timeout,
    output logic [2:0] gpio_data,
    output logic       gpio_strobe,
    input  logic       gpio_ack,
    output logic [2:0] led_code,
    output logic [6:0] hex_display
);

    // Counter is shared by the setup delay and all ack-wait timeouts.
    localparam int CNT_MAX = (ACK_TIMEOUT > SETUP_CYCLES) ? ACK_TIMEOUT : SETUP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       ack_sync_reg;
    logic             ack_s;
    logic [2:0]       code_next;

    // Active-low segment pattern {g,f,e,d,c,b,a}, same table as the sensor readback.
    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

    // Box numbering on the wire is one below the game's numbering, wrapping 0 -> 7.
    assign code_next = box_addr - 3'd1;
    assign ack_s     = ack_sync_reg[1];
    assign ready     = (state_reg == IDLE);

    // Two-flop synchronizer for the asynchronous acknowledge from the controller.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            ack_sync_reg <= 2'b00;
        end else begin
            ack_sync_reg <= {ack_sync_reg[0], gpio_ack};
        end
    end

    // Handshake FSM with registered outputs; done/timeout default low so they pulse.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            gpio_data   <= 3'd0;
            gpio_strobe <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            led_code    <= 3'd0;
            hex_display <= 7'b1000000;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (send) begin
                        state_reg   <= SETUP;
                        gpio_data   <= code_next;
                        led_code    <= code_next;
                        hex_display <= seg7(code_next);
                        cnt_reg     <= '0;
                    end
                end
                SETUP: begin
                    // A stale ack from a previous exchange must clear before strobing.
                    if (cnt_reg >= SETUP_LAST && !ack_s) begin
                        state_reg   <= STROBE;
                        gpio_strobe <= 1'b1;
                        cnt_reg     <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg   <= IDLE;
                        gpio_strobe <= 1'b0;
                        timeout     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (ack_s) begin
                        state_reg   <= RELEASE;
                        gpio_strobe <= 1'b0;
                        cnt_reg     <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg   <= IDLE;
                        gpio_strobe <= 1'b0;
                        timeout     <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (!ack_s) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg <= IDLE;
                        timeout   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    gpio_strobe <= 1'b0;
                end
            endcase
        end
    end

endmodule
